// File: rtl/code_lock_ctrl_if.sv
// Signal bundle between the switch-entry stage, the lock controller and the
// display/LED stage. The entry stage and display side act as master; the
// lock controller is the slave.
interface code_lock_ctrl_if;
  // Entry side: four BCD digits (digit k at [4k+3:4k], 4'hF = empty),
  // number of digits typed so far, debounced confirm level, admin switch.
  logic [15:0] SEQUENCE;
  logic [2:0]  SEQUENCE_BIT;
  logic        CONFIRM;
  logic        ADMIN_MODE;

  // Controller side: lock/alarm levels, single-cycle event pulses and status.
  logic        UNLOCK;
  logic        ALARM;
  logic        ERR_FLAG;
  logic        CODE_SET_DONE;
  logic        SEQ_CLR;
  logic [2:0]  FAIL_CNT;
  logic [2:0]  STATE;

  modport master (
    output SEQUENCE, SEQUENCE_BIT, CONFIRM, ADMIN_MODE,
    input  UNLOCK, ALARM, ERR_FLAG, CODE_SET_DONE, SEQ_CLR, FAIL_CNT, STATE
  );

  modport slave (
    input  SEQUENCE, SEQUENCE_BIT, CONFIRM, ADMIN_MODE,
    output UNLOCK, ALARM, ERR_FLAG, CODE_SET_DONE, SEQ_CLR, FAIL_CNT, STATE
  );
endinterface

// File: rtl/code_lock_ctrl.sv
// Code lock controller: checks a confirmed 4-digit entry against the stored
// user code (or the admin key in admin mode), drives unlock / lockout / alarm,
// and lets a new user code be programmed after a successful admin login.
// All event outputs are registered, so every pulse appears one cycle after
// the decision that caused it.
module code_lock_ctrl #(
  parameter logic [15:0] DEFAULT_CODE = 16'h1234,
  parameter logic [15:0] ADMIN_KEY    = 16'h9876,
  parameter int unsigned MAX_FAIL     = 3,
  parameter logic [31:0] OPEN_CYCLES  = 32'd50_000_000,
  parameter logic [31:0] LOCK_CYCLES  = 32'd500_000_000
) (
  input  logic                   CLK,
  input  logic                   RESET,
  code_lock_ctrl_if.slave        bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_LOCKOUT = 3'd4,
    ST_SET_NEW = 3'd5
  } state_e;

  localparam logic [2:0]  MaxFail  = 3'(MAX_FAIL);
  localparam logic [31:0] OpenLast = OPEN_CYCLES - 32'd1;
  localparam logic [31:0] LockLast = LOCK_CYCLES - 32'd1;

  // A usable entry has all four digits typed and each digit is decimal.
  function automatic logic entry_is_valid(input logic [15:0] seq,
                                          input logic [2:0]  cnt);
    logic ok;
    ok = (cnt == 3'd4);
    for (int d = 0; d < 4; d++) begin
      if (seq[4*d +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] code_q, code_d;
  logic [15:0] entry_q, entry_d;
  logic        admin_q, admin_d;
  logic [31:0] timer_q, timer_d;
  logic [2:0]  fail_cnt_q, fail_cnt_d;
  logic        confirm_q;

  logic        unlock_q, unlock_d;
  logic        alarm_q, alarm_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        seq_clr_q, seq_clr_d;

  logic        conf_edge;
  logic        entry_ok;
  logic        open_expired;
  logic        lock_expired;
  logic [2:0]  fail_cnt_inc;

  // One edge per press; holding the button produces nothing further.
  assign conf_edge    = bus.CONFIRM & ~confirm_q;
  assign entry_ok     = entry_is_valid(bus.SEQUENCE, bus.SEQUENCE_BIT);
  assign open_expired = (timer_q == OpenLast);
  assign lock_expired = (timer_q == LockLast);
  assign fail_cnt_inc = (fail_cnt_q == 3'd7) ? 3'd7 : fail_cnt_q + 3'd1;

  // State register together with the datapath registers it governs.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (RESET) begin
      state_q    <= ST_IDLE;
      code_q     <= DEFAULT_CODE;
      entry_q    <= '0;
      admin_q    <= 1'b0;
      timer_q    <= '0;
      fail_cnt_q <= '0;
      confirm_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      entry_q    <= entry_d;
      admin_q    <= admin_d;
      timer_q    <= timer_d;
      fail_cnt_q <= fail_cnt_d;
      confirm_q  <= bus.CONFIRM;
    end
  end

  // Next-state and datapath update decisions.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    code_d     = code_q;
    entry_d    = entry_q;
    admin_d    = admin_q;
    fail_cnt_d = fail_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        // Invalid entries are rejected here without touching the fail count.
        if (conf_edge && entry_ok) begin
          state_d = ST_CHECK;
          entry_d = bus.SEQUENCE;
          admin_d = bus.ADMIN_MODE;
        end
      end
      ST_CHECK: begin
        if (admin_q && (entry_q == ADMIN_KEY)) begin
          state_d = ST_SET_NEW;
        end else if (!admin_q && (entry_q == code_q)) begin
          state_d    = ST_OPEN;
          fail_cnt_d = 3'd0;
        end else begin
          fail_cnt_d = fail_cnt_inc;
          state_d    = (fail_cnt_inc >= MaxFail) ? ST_LOCKOUT : ST_FAIL;
        end
      end
      ST_OPEN: begin
        // A press re-locks early; coinciding with expiry it is simply absorbed.
        if (conf_edge || open_expired) state_d = ST_IDLE;
      end
      ST_FAIL: begin
        state_d = ST_IDLE;
      end
      ST_LOCKOUT: begin
        // Presses are ignored for the whole lockout window.
        if (lock_expired) begin
          state_d    = ST_IDLE;
          fail_cnt_d = 3'd0;
        end
      end
      ST_SET_NEW: begin
        // Dropping the admin switch wins over any press in the same cycle.
        if (!bus.ADMIN_MODE) begin
          state_d = ST_IDLE;
        end else if (conf_edge && entry_ok) begin
          code_d  = bus.SEQUENCE;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The timer restarts on every state change and only runs in timed states.
    timer_d = '0;
    if ((state_d == state_q) && ((state_q == ST_OPEN) || (state_q == ST_LOCKOUT))) begin
      timer_d = timer_q + 32'd1;
    end
  end

  // Output decode: levels from the next state, pulses from the decision taken.
  always_comb begin
    unlock_d  = (state_d == ST_OPEN);
    alarm_d   = (state_d == ST_LOCKOUT);
    err_d     = 1'b0;
    done_d    = 1'b0;
    seq_clr_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (conf_edge && !entry_ok) begin
          err_d     = 1'b1;
          seq_clr_d = 1'b1;
        end
      end
      ST_CHECK: begin
        // Every mismatch flags an error, whether it leads to FAIL or LOCKOUT;
        // on the FAIL path the pulse lands exactly in the FAIL cycle.
        seq_clr_d = 1'b1;
        err_d     = (state_d == ST_FAIL) || (state_d == ST_LOCKOUT);
      end
      ST_SET_NEW: begin
        if (bus.ADMIN_MODE && conf_edge) begin
          seq_clr_d = 1'b1;
          done_d    = entry_ok;
          err_d     = !entry_ok;
        end
      end
      default: begin
      end
    endcase
  end

  // Output registers keep UNLOCK/ALARM and the event pulses glitch-free.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      unlock_q  <= 1'b0;
      alarm_q   <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      seq_clr_q <= 1'b0;
    end else begin
      unlock_q  <= unlock_d;
      alarm_q   <= alarm_d;
      err_q     <= err_d;
      done_q    <= done_d;
      seq_clr_q <= seq_clr_d;
    end
  end

  assign bus.UNLOCK        = unlock_q;
  assign bus.ALARM         = alarm_q;
  assign bus.ERR_FLAG      = err_q;
  assign bus.CODE_SET_DONE = done_q;
  assign bus.SEQ_CLR       = seq_clr_q;
  assign bus.FAIL_CNT      = fail_cnt_q;
  assign bus.STATE         = state_q;

endmodule

// File: doc/code_lock_ctrl.md
Name: code_lock_ctrl

Overview:
Downstream consumer of the switch-entry stage. Takes the 4-digit BCD SEQUENCE and the digit count SEQUENCE_BIT from that stage, plus a confirm button and an admin-mode switch. It verifies the entry against a stored user code or the admin key, then drives unlock, lockout and alarm. In admin mode it also lets a new user code be programmed. Its outputs feed the display/LED stage and send a sequence-clear request back upstream.

Parameters:
DEFAULT_CODE, 16'h1234, user code loaded on reset (digit0 in [3:0])
ADMIN_KEY, 16'h9876, fixed admin key
MAX_FAIL, 3, consecutive mismatches that trigger LOCKOUT (range 1..7)
OPEN_CYCLES, 32'd50_000_000, cycles UNLOCK stays high
LOCK_CYCLES, 32'd500_000_000, cycles LOCKOUT lasts

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
SEQUENCE  in  16  four BCD digits; digit k at [4k+3:4k]; 4'hF = empty
SEQUENCE_BIT  in  3  digits entered so far (0..4)
CONFIRM  in  1  confirm button level, already debounced
ADMIN_MODE  in  1  admin switch level
UNLOCK  out  1  lock open
ALARM  out  1  high during LOCKOUT
ERR_FLAG  out  1  1-cycle pulse: invalid entry or mismatch
CODE_SET_DONE  out  1  1-cycle pulse: new user code stored
SEQ_CLR  out  1  1-cycle pulse: upstream must clear SEQUENCE/SEQUENCE_BIT
FAIL_CNT  out  3  consecutive mismatch count
STATE  out  3  IDLE=0, CHECK=1, OPEN=2, FAIL=3, LOCKOUT=4, SET_NEW=5

Behaviour:
- Reset (RESET=1 at a clock edge, including mid-operation): state IDLE, stored code=DEFAULT_CODE, timer=0, FAIL_CNT=0, CONFIRM history=0. All outputs 0.
- The confirm edge is internal: conf_edge = CONFIRM & ~CONFIRM_q. CONFIRM_q is a register. Each press produces exactly one edge; holding the button has no further effect.
- An entry is valid when SEQUENCE_BIT==4 and every nibble is <= 9. Otherwise it is invalid.
- IDLE, on conf_edge:
  - Invalid entry: ERR_FLAG and SEQ_CLR pulse in the next cycle. Stay in IDLE. FAIL_CNT unchanged.
  - Valid entry: go to CHECK, latching SEQUENCE and ADMIN_MODE.
- CHECK (exactly 1 cycle). SEQ_CLR pulses on exit.
  - Latched admin=1 and entry==ADMIN_KEY: go to SET_NEW. FAIL_CNT unchanged.
  - Latched admin=0 and entry==stored code: go to OPEN. FAIL_CNT=0.
  - Any other case: FAIL_CNT+1. If the new value >= MAX_FAIL, go to LOCKOUT; otherwise go to FAIL.
- Latency: conf_edge in cycle n, CHECK in cycle n+1, OPEN with UNLOCK=1 from cycle n+2.
- OPEN: UNLOCK=1. The timer counts 0..OPEN_CYCLES-1, then the block returns to IDLE with UNLOCK=0. A conf_edge during OPEN re-locks immediately (go to IDLE). If the edge and timer expiry coincide, go to IDLE once; the edge is consumed and not evaluated as a new entry.
- FAIL: ERR_FLAG=1 for this single cycle, then IDLE.
- LOCKOUT: ALARM=1 and all conf_edge are ignored (no SEQ_CLR). After LOCK_CYCLES: FAIL_CNT=0, ALARM=0, go to IDLE.
- SET_NEW, evaluated in priority order:
  - ADMIN_MODE=0: abort to IDLE, code unchanged.
  - conf_edge with a valid entry: stored code=SEQUENCE, CODE_SET_DONE and SEQ_CLR pulse, go to IDLE.
  - conf_edge with an invalid entry: ERR_FLAG and SEQ_CLR pulse, stay in SET_NEW.
- The timer is 32-bit and clears on every state entry. FAIL_CNT saturates at 7.
- UNLOCK and ALARM are registered, decoded from the next state, so they are glitch-free.

Test Plan (OPEN_CYCLES=8, LOCK_CYCLES=16, MAX_FAIL=3):
1. Reset, then SEQUENCE=16'h1234, SEQUENCE_BIT=4, CONFIRM pulse -> STATE 1 then 2. UNLOCK=1 for exactly 8 cycles. SEQ_CLR pulses once. FAIL_CNT=0.
2. SEQUENCE_BIT=3, CONFIRM -> ERR_FLAG and SEQ_CLR pulse once, STATE stays 0, FAIL_CNT=0. Repeat with SEQUENCE=16'h12A4 and SEQUENCE_BIT=4 -> same response.
3. Three confirms of 16'h0000 -> FAIL_CNT=1, 2, then 3 with STATE=4 and ALARM=1 for 16 cycles. A CONFIRM during lockout produces no pulses. Afterwards FAIL_CNT=0 and 16'h1234 opens.
4. ADMIN_MODE=1, confirm 16'h9876 -> STATE=5. Confirm 16'h5555 -> CODE_SET_DONE pulse. ADMIN_MODE=0: 16'h5555 opens and 16'h1234 gives ERR_FLAG.
5. In SET_NEW, drop ADMIN_MODE -> IDLE and code unchanged. Assert RESET during OPEN -> UNLOCK=0 next cycle and stored code back to 16'h1234.
6. During OPEN, a CONFIRM edge on the same cycle the timer expires -> single return to IDLE, no CHECK entry. Holding CONFIRM high for 10 cycles -> only one evaluation.
